multicycle_control: RTL and testbench

Main control unit for the multi-cycle datapath: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It sits directly upstream of the ALU and generates its 3-bit `ALUcontrol` from opcode and funct. No separate ALU-decoder stage is used. It consumes the ALU `zero` flag to resolve branches.

---
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control
// Description : Moore control FSM for the multi-cycle datapath, including the
//               ALU operation decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_sub   = 6'b100010;
  localparam logic [5:0] c_fn_and   = 6'b100100;
  localparam logic [5:0] c_fn_or    = 6'b100101;
  localparam logic [5:0] c_fn_slt   = 6'b101010;

  localparam logic [2:0] c_alu_or   = 3'b000;
  localparam logic [2:0] c_alu_and  = 3'b001;
  localparam logic [2:0] c_alu_add  = 3'b010;
  localparam logic [2:0] c_alu_sub  = 3'b110;
  localparam logic [2:0] c_alu_slt  = 3'b111;

  state_t     r_state;
  state_t     w_dec_state;
  logic [2:0] w_funct_alu;
  logic       w_funct_ok;
  logic       w_pc_write;
  logic       w_branch;

  assign state = r_state;

  always_comb begin
    w_funct_alu = c_alu_add;
    w_funct_ok  = 1'b1;
    case (funct)
      c_fn_add: w_funct_alu = c_alu_add;
      c_fn_sub: w_funct_alu = c_alu_sub;
      c_fn_and: w_funct_alu = c_alu_and;
      c_fn_or:  w_funct_alu = c_alu_or;
      c_fn_slt: w_funct_alu = c_alu_slt;
      default:  w_funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            c_op_lw, c_op_sw: r_state <= S_MEMADR;
            c_op_rtype:       r_state <= S_EXEC;
            c_op_beq:         r_state <= S_BRANCH;
            c_op_addi:        r_state <= S_ADDIEX;
            c_op_j:           r_state <= S_JUMP;
            default:          r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (opcode == c_op_lw)      r_state <= S_MEMRD;
          else if (opcode == c_op_sw) r_state <= S_MEMWR;
          else                        r_state <= S_FETCH;
        end
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the decode shows FETCH, with all write-type strobes masked.
  always_comb begin
    w_dec_state = reset ? S_FETCH : r_state;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = c_alu_add;
    pc_src      = 2'b00;
    illegal     = 1'b0;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = 2'b01;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          c_op_lw, c_op_sw, c_op_rtype, c_op_beq, c_op_addi, c_op_j: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_funct_alu;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = w_funct_ok;
        illegal   = ~w_funct_ok;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = c_alu_sub;
        pc_src      = 2'b01;
        w_branch    = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign pc_en = ~reset & (w_pc_write | (w_branch & zero));

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] alu_tab[6];
  logic       ok_tab [6];

  initial begin
    fn_tab[0] = 6'b100010; alu_tab[0] = 3'b110; ok_tab[0] = 1'b1;
    fn_tab[1] = 6'b100100; alu_tab[1] = 3'b001; ok_tab[1] = 1'b1;
    fn_tab[2] = 6'b100101; alu_tab[2] = 3'b000; ok_tab[2] = 1'b1;
    fn_tab[3] = 6'b101010; alu_tab[3] = 3'b111; ok_tab[3] = 1'b1;
    fn_tab[4] = 6'b100000; alu_tab[4] = 3'b010; ok_tab[4] = 1'b1;
    fn_tab[5] = 6'b000000; alu_tab[5] = 3'b010; ok_tab[5] = 1'b0;

    reset = 1'b1; opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
    cyc();
    cyc();
    check("rst_state", state, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_mem_read", mem_read, 1);
    check("rst_alu_src_b", alu_src_b, 2'b01);
    check("rst_illegal", illegal, 0);

    // lw
    reset = 1'b0;
    #1;
    check("lw_f_state", state, 0);
    check("lw_f_pc_en", pc_en, 1);
    check("lw_f_ir_write", ir_write, 1);
    check("lw_f_alu", alu_control, 3'b010);
    cyc();
    check("lw_d_state", state, 1);
    check("lw_d_srcb", alu_src_b, 2'b11);
    check("lw_d_pc_en", pc_en, 0);
    cyc();
    check("lw_ma_state", state, 2);
    check("lw_ma_srca", alu_src_a, 1);
    check("lw_ma_srcb", alu_src_b, 2'b10);
    cyc();
    check("lw_mr_state", state, 3);
    check("lw_mr_iord", iord, 1);
    check("lw_mr_mem_read", mem_read, 1);
    check("lw_mr_reg_write", reg_write, 0);
    check("lw_mr_pc_en", pc_en, 0);
    cyc();
    check("lw_wb_state", state, 4);
    check("lw_wb_reg_write", reg_write, 1);
    check("lw_wb_mem_to_reg", mem_to_reg, 1);
    check("lw_wb_reg_dst", reg_dst, 0);
    cyc();
    check("lw_end_state", state, 0);

    // R-type, including an unsupported funct
    for (int i = 0; i < 6; i++) begin
      opcode = 6'b000000; funct = fn_tab[i];
      cyc();
      check("r_d_state", state, 1);
      cyc();
      check("r_ex_state", state, 6);
      check("r_ex_alu", alu_control, alu_tab[i]);
      check("r_ex_srca", alu_src_a, 1);
      check("r_ex_srcb", alu_src_b, 2'b00);
      cyc();
      check("r_wb_state", state, 7);
      check("r_wb_reg_write", reg_write, ok_tab[i]);
      check("r_wb_reg_dst", reg_dst, 1);
      check("r_wb_illegal", illegal, !ok_tab[i]);
      cyc();
      check("r_end_state", state, 0);
    end

    // beq, both zero values in the BRANCH cycle
    opcode = 6'b000100; zero = 1'b1;
    cyc();
    check("beq_d_state", state, 1);
    cyc();
    check("beq_b_state", state, 8);
    check("beq_b_pc_en_z1", pc_en, 1);
    check("beq_b_pc_src", pc_src, 2'b01);
    check("beq_b_alu", alu_control, 3'b110);
    zero = 1'b0;
    #1;
    check("beq_b_pc_en_z0", pc_en, 0);
    cyc();
    check("beq_end_state", state, 0);

    // illegal opcode
    opcode = 6'b111111;
    cyc();
    check("ill_d_state", state, 1);
    check("ill_d_illegal", illegal, 1);
    check("ill_d_reg_write", reg_write, 0);
    check("ill_d_mem_write", mem_write, 0);
    cyc();
    check("ill_end_state", state, 0);
    check("ill_end_illegal", illegal, 0);

    // sw
    opcode = 6'b101011;
    cyc();
    check("sw_d_state", state, 1);
    cyc();
    check("sw_ma_state", state, 2);
    cyc();
    check("sw_mw_state", state, 5);
    check("sw_mw_mem_write", mem_write, 1);
    check("sw_mw_iord", iord, 1);
    check("sw_mw_reg_write", reg_write, 0);
    cyc();
    check("sw_end_state", state, 0);

    // j
    opcode = 6'b000010;
    cyc();
    check("j_d_state", state, 1);
    cyc();
    check("j_j_state", state, 11);
    check("j_j_pc_en", pc_en, 1);
    check("j_j_pc_src", pc_src, 2'b10);
    cyc();
    check("j_end_state", state, 0);

    // addi
    opcode = 6'b001000;
    cyc();
    cyc();
    check("addi_ex_state", state, 9);
    check("addi_ex_srcb", alu_src_b, 2'b10);
    cyc();
    check("addi_wb_state", state, 10);
    check("addi_wb_reg_write", reg_write, 1);
    check("addi_wb_reg_dst", reg_dst, 0);
    check("addi_wb_mem_to_reg", mem_to_reg, 0);
    cyc();
    check("addi_end_state", state, 0);

    // reset during MEMRD of a lw
    opcode = 6'b100011;
    cyc();
    cyc();
    cyc();
    check("rlw_mr_state", state, 3);
    reset = 1'b1;
    #1;
    check("rlw_mr_iord", iord, 0);
    check("rlw_mr_mem_read", mem_read, 1);
    check("rlw_mr_pc_en", pc_en, 0);
    cyc();
    check("rlw_r1_state", state, 0);
    check("rlw_r1_reg_write", reg_write, 0);
    check("rlw_r1_ir_write", ir_write, 0);
    cyc();
    check("rlw_r2_state", state, 0);
    check("rlw_r2_pc_en", pc_en, 0);
    check("rlw_r2_mem_write", mem_write, 0);
    reset = 1'b0;
    #1;
    check("rlw_rel_pc_en", pc_en, 1);
    cyc();
    check("rlw_rel_state", state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
